// File: rtl/spi_pkg.sv
// Shared definitions for the arbitrated SPI master: FSM encoding and default sizing.
package spi_pkg;

    localparam int SPI_DW_DEF      = 8;
    localparam int SPI_CLK_DIV_DEF = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_SHIFT = 3'd2,
        ST_HOLD  = 3'd3,
        ST_DONE  = 3'd4,
        ST_GAP   = 3'd5
    } spi_state_e;

endpackage

// File: rtl/spi_shift_engine.sv
// SPI mode-0 shift/clock engine: MSB-first transmit, receive into LSB on each
// SCLK rise, and a finish pulse in the cycle that produces the last falling edge.
module spi_shift_engine
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int DW      = SPI_DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_load,
    input  logic [DW-1:0] i_tx,
    input  logic          i_start,
    input  logic          i_miso,
    output logic          o_sclk,
    output logic          o_mosi,
    output logic [DW-1:0] o_rx,
    output logic          o_finish
);
    localparam int HW = $clog2(CLK_DIV + 1);
    localparam int BW = $clog2(DW + 1);
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_DIV - 1);

    logic          r_active;
    logic [HW-1:0] r_hcnt;
    logic [BW-1:0] r_bcnt;
    logic          r_sclk;
    logic [DW-1:0] r_tx;
    logic [DW-1:0] r_rx;
    logic          w_tick;

    assign w_tick   = r_active && (r_hcnt == '0);
    // r_bcnt counts remaining rising edges; zero on a high phase means the last fall is due
    assign o_finish = w_tick && r_sclk && (r_bcnt == '0);
    assign o_sclk   = r_sclk;
    assign o_mosi   = r_tx[DW-1];
    assign o_rx     = r_rx;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_active <= 1'b0;
            r_hcnt   <= '0;
            r_bcnt   <= '0;
            r_sclk   <= 1'b0;
            r_tx     <= '0;
            r_rx     <= '0;
        end else begin
            if (i_load) begin
                r_tx <= i_tx;
            end
            if (i_start) begin
                r_active <= 1'b1;
                r_hcnt   <= HALF_LAST;
                r_bcnt   <= BW'(DW);
                r_sclk   <= 1'b0;
            end else if (r_active) begin
                if (w_tick) begin
                    r_hcnt <= HALF_LAST;
                    r_sclk <= ~r_sclk;
                    if (!r_sclk) begin
                        r_rx   <= {r_rx[DW-2:0], i_miso};
                        r_bcnt <= r_bcnt - 1'b1;
                    end else begin
                        r_tx <= {r_tx[DW-2:0], 1'b0};
                        if (r_bcnt == '0) begin
                            r_active <= 1'b0;
                        end
                    end
                end else begin
                    r_hcnt <= r_hcnt - 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/spi_arb_master.sv
// Two-requester SPI master: round-robin arbitration and transfer sequencing
// around the shared shift engine.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ss high, arbitrate, grant winner and latch its byte
//   ST_SETUP | ss low, first MSB on mosi, CLK_DIV cycles
//   ST_SHIFT | engine toggles sclk, 2*DW*CLK_DIV cycles
//   ST_HOLD  | ss low, sclk low, CLK_DIV cycles
//   ST_DONE  | one cycle, done pulse to the served requester
//   ST_GAP   | ss high, mosi low, CLK_DIV cycles before re-arbitrating
module spi_arb_master
    import spi_pkg::*;
#(
    parameter int CLK_DIV = SPI_CLK_DIV_DEF,
    parameter int DW      = SPI_DW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          req1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          gnt0,
    output logic          gnt1,
    output logic          done0,
    output logic          done1,
    output logic [DW-1:0] rdata0,
    output logic [DW-1:0] rdata1,
    output logic          ss,
    output logic          sclk,
    output logic          mosi,
    input  logic          miso,
    output logic          busy
);
    localparam int TW = $clog2(CLK_DIV + 1);
    localparam logic [TW-1:0] T_LAST = TW'(CLK_DIV - 1);

    spi_state_e    r_state;
    spi_state_e    w_next;
    logic [TW-1:0] r_tmr;
    logic          r_sel;
    logic          r_last;
    logic [DW-1:0] r_rdata0;
    logic [DW-1:0] r_rdata1;

    logic          w_win;
    logic          w_grant;
    logic          w_tmr_load;
    logic          w_tmr_zero;
    logic          w_start;
    logic          w_finish;
    logic          w_load_rx;
    logic          w_eng_mosi;
    logic [DW-1:0] w_tx;
    logic [DW-1:0] w_rx;

    // r_last resets to 1 so requester 0 wins the first contested round
    assign w_win      = (req0 && req1) ? ~r_last : req1;
    assign w_tx       = w_win ? wdata1 : wdata0;
    assign w_tmr_zero = (r_tmr == '0);
    assign rdata0     = r_rdata0;
    assign rdata1     = r_rdata1;

    spi_shift_engine #(
        .CLK_DIV (CLK_DIV),
        .DW      (DW)
    ) u_engine (
        .clk      (clk),
        .rst      (rst),
        .i_load   (w_grant),
        .i_tx     (w_tx),
        .i_start  (w_start),
        .i_miso   (miso),
        .o_sclk   (sclk),
        .o_mosi   (w_eng_mosi),
        .o_rx     (w_rx),
        .o_finish (w_finish)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next     = r_state;
        w_grant    = 1'b0;
        w_tmr_load = 1'b0;
        w_start    = 1'b0;
        w_load_rx  = 1'b0;
        ss         = 1'b1;
        busy       = 1'b1;
        mosi       = 1'b0;
        gnt0       = 1'b0;
        gnt1       = 1'b0;
        done0      = 1'b0;
        done1      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                busy = 1'b0;
                // rst gate keeps the grant quiet while reset holds the FSM in IDLE
                if (rst && (req0 || req1)) begin
                    w_grant    = 1'b1;
                    gnt0       = ~w_win;
                    gnt1       = w_win;
                    w_tmr_load = 1'b1;
                    w_next     = ST_SETUP;
                end
            end
            ST_SETUP: begin
                ss   = 1'b0;
                mosi = w_eng_mosi;
                if (w_tmr_zero) begin
                    w_start = 1'b1;
                    w_next  = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                ss   = 1'b0;
                mosi = w_eng_mosi;
                if (w_finish) begin
                    w_tmr_load = 1'b1;
                    w_next     = ST_HOLD;
                end
            end
            ST_HOLD: begin
                ss = 1'b0;
                if (w_tmr_zero) begin
                    w_load_rx = 1'b1;
                    w_next    = ST_DONE;
                end
            end
            ST_DONE: begin
                done0      = ~r_sel;
                done1      = r_sel;
                w_tmr_load = 1'b1;
                w_next     = ST_GAP;
            end
            ST_GAP: begin
                if (w_tmr_zero) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tmr <= '0;
        end else if (w_tmr_load) begin
            r_tmr <= T_LAST;
        end else if (!w_tmr_zero) begin
            r_tmr <= r_tmr - 1'b1;
        end
    end

    // rdata is loaded leaving HOLD so the new byte is visible alongside done
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sel    <= 1'b0;
            r_last   <= 1'b1;
            r_rdata0 <= '0;
            r_rdata1 <= '0;
        end else begin
            if (w_grant) begin
                r_sel  <= w_win;
                r_last <= w_win;
            end
            if (w_load_rx) begin
                if (r_sel) begin
                    r_rdata1 <= w_rx;
                end else begin
                    r_rdata0 <= w_rx;
                end
            end
        end
    end

endmodule

// File: tb/tb_spi_arb_master.sv
// Bench for spi_arb_master: cycle-accurate transaction model for the default
// instance plus directed checks on a CLK_DIV=1 instance.
module tb_spi_arb_master;
    localparam int DW  = 8;
    localparam int C   = 2;
    localparam int TOT = (2*DW+2)*C;   // last cycle after gnt with ss low
    localparam int D   = TOT + 1;      // done cycle after gnt

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       req0, req1, miso;
    logic [7:0] wdata0, wdata1;
    logic       gnt0, gnt1, done0, done1, ss, sclk, mosi, busy;
    logic [7:0] rdata0, rdata1;

    logic       req0_b, req1_b, miso_b;
    logic [7:0] wdata0_b, wdata1_b;
    logic       gnt0_b, gnt1_b, done0_b, done1_b, ss_b, sclk_b, mosi_b, busy_b;
    logic [7:0] rdata0_b, rdata1_b;

    logic [7:0] slave_byte;
    int vec = 0;
    int err = 0;
    int cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    spi_arb_master dut (
        .clk(clk), .rst(rst), .req0(req0), .req1(req1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1), .rdata0(rdata0), .rdata1(rdata1),
        .ss(ss), .sclk(sclk), .mosi(mosi), .miso(miso), .busy(busy)
    );

    spi_arb_master #(.CLK_DIV(1), .DW(8)) dut_b (
        .clk(clk), .rst(rst), .req0(req0_b), .req1(req1_b), .wdata0(wdata0_b), .wdata1(wdata1_b),
        .gnt0(gnt0_b), .gnt1(gnt1_b), .done0(done0_b), .done1(done1_b), .rdata0(rdata0_b), .rdata1(rdata1_b),
        .ss(ss_b), .sclk(sclk_b), .mosi(mosi_b), .miso(miso_b), .busy(busy_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vec++;
        if (act !== exp) begin
            err++;
            $display("FAIL %s at cycle %0d: got %0h, want %0h", nm, cyc, act, exp);
        end
    endtask

    // Slave: presents MSB while selected, moves to the next bit after each SCLK fall.
    initial begin : slave
        logic [7:0] sh;
        logic       ps;
        miso = 1'b0;
        sh   = '0;
        ps   = 1'b0;
        forever begin
            @(negedge clk);
            if (ss !== 1'b0) sh = slave_byte;
            else if (ps && !sclk) sh = {sh[6:0], 1'b0};
            miso = (ss !== 1'b0) ? 1'b0 : sh[7];
            ps = sclk;
        end
    end

    // Transaction model: every output of the default instance is a function of
    // the cycle offset k from the grant, the granted byte and the slave byte.
    initial begin : model
        bit         act, last;
        int         k, id, j, h;
        logic [7:0] mw, ms, mrx0, mrx1;
        logic       eg0, eg1;
        act = 0; last = 1; k = 0; id = 0; mw = '0; ms = '0; mrx0 = '0; mrx1 = '0;
        forever begin
            @(negedge clk);
            if (rst !== 1'b1) begin
                act = 0; last = 1; mrx0 = '0; mrx1 = '0;
                chk("rst_ss", ss, 1);       chk("rst_sclk", sclk, 0);   chk("rst_mosi", mosi, 0);
                chk("rst_gnt0", gnt0, 0);   chk("rst_gnt1", gnt1, 0);   chk("rst_done0", done0, 0);
                chk("rst_done1", done1, 0); chk("rst_busy", busy, 0);
                chk("rst_rdata0", rdata0, 0); chk("rst_rdata1", rdata1, 0);
            end else if (!act) begin
                eg0 = 0; eg1 = 0;
                chk("idle_ss", ss, 1);       chk("idle_sclk", sclk, 0);   chk("idle_mosi", mosi, 0);
                chk("idle_busy", busy, 0);   chk("idle_done0", done0, 0); chk("idle_done1", done1, 0);
                chk("idle_rdata0", rdata0, mrx0); chk("idle_rdata1", rdata1, mrx1);
                if (req0 || req1) begin
                    if (req0 && req1) id = last ? 0 : 1;
                    else              id = req1 ? 1 : 0;
                    if (id == 0) eg0 = 1; else eg1 = 1;
                    mw   = (id == 1) ? wdata1 : wdata0;
                    ms   = slave_byte;
                    last = (id == 1);
                    act  = 1;
                    k    = 1;
                end
                chk("idle_gnt0", gnt0, eg0); chk("idle_gnt1", gnt1, eg1);
            end else begin
                if (k == D) begin
                    if (id == 0) mrx0 = ms; else mrx1 = ms;
                end
                chk("xfer_gnt0", gnt0, 0); chk("xfer_gnt1", gnt1, 0); chk("xfer_busy", busy, 1);
                chk("xfer_done0", done0, (k == D && id == 0));
                chk("xfer_done1", done1, (k == D && id == 1));
                chk("xfer_rdata0", rdata0, mrx0); chk("xfer_rdata1", rdata1, mrx1);
                if (k <= TOT)   chk("xfer_ss_low", ss, 0);
                else if (k > D) chk("gap_ss_high", ss, 1);
                if (k > C && k <= C + 2*DW*C) begin
                    j = k - C - 1;
                    h = j / C;
                    chk("shift_sclk", sclk, h % 2);
                    chk("shift_mosi", mosi, mw[DW-1-h/2]);
                end else begin
                    chk("xfer_sclk_low", sclk, 0);
                    if (k <= C)     chk("setup_mosi", mosi, mw[DW-1]);
                    else if (k > D) chk("gap_mosi", mosi, 0);
                end
                k++;
                if (k > D + C) act = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (!busy) break;
        end
        chk("idle_reached", (n < 200), 1);
        tick();
    endtask

    task automatic wait_gnt(output int who, output int gcyc);
        int n;
        n = 0;
        who = -1;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (gnt0) begin who = 0; break; end
            if (gnt1) begin who = 1; break; end
        end
        gcyc = cyc;
        chk("gnt_seen", (who >= 0), 1);
    endtask

    task automatic watch(input int who, input int gcyc, output logic [7:0] bits, output int lat);
        logic ps;
        int   n;
        ps = 1'b0; bits = '0; lat = -1; n = 0;
        while (n < 200) begin
            @(negedge clk);
            n++;
            if (sclk && !ps) bits = {bits[6:0], mosi};
            ps = sclk;
            if ((who == 0 && done0) || (who == 1 && done1)) begin
                lat = cyc - gcyc;
                break;
            end
        end
    endtask

    task automatic watch_b(input int who, output logic [7:0] bits, output int rises, output int lat);
        logic ps;
        int   n, gcyc, prev;
        ps = 1'b0; bits = '0; rises = 0; lat = -1; n = 0; prev = -1; gcyc = -1;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if ((who == 0 && gnt0_b) || (who == 1 && gnt1_b)) begin gcyc = cyc; break; end
        end
        chk("b_gnt_seen", (gcyc >= 0), 1);
        tick();
        req0_b = 1'b0; req1_b = 1'b0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (sclk_b && !ps) begin
                bits = {bits[6:0], mosi_b};
                rises++;
                if (prev >= 0) chk("b_sclk_period", cyc - prev, 2);
                prev = cyc;
            end
            ps = sclk_b;
            if ((who == 0 && done0_b) || (who == 1 && done1_b)) begin
                lat = cyc - gcyc;
                break;
            end
        end
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int         who, g, lat, n, rises, cnt, r;
        int         gw[4];
        logic [7:0] bits;
        logic       ps, g0, g1, pend0, pend1;

        rst = 1'b0; req0 = 0; req1 = 0; wdata0 = '0; wdata1 = '0; slave_byte = '0;
        req0_b = 0; req1_b = 0; wdata0_b = '0; wdata1_b = '0; miso_b = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        repeat (3) tick();

        // reset asserted mid-idle takes effect within the cycle
        rst = 1'b0;
        #1;
        chk("r28_ss", ss, 1);   chk("r28_sclk", sclk, 0); chk("r28_mosi", mosi, 0);
        chk("r28_busy", busy, 0); chk("r28_gnt", {gnt1, gnt0}, 0); chk("r28_done", {done1, done0}, 0);
        chk("r28_rdata", {rdata1, rdata0}, 0);
        tick();
        rst = 1'b1;
        tick();

        // 0x5B out, 0xA6 back; wdata change after grant must be ignored
        slave_byte = 8'hA6; wdata0 = 8'h5B; req0 = 1'b1;
        wait_gnt(who, g);
        chk("t1_who", who, 0);
        tick();
        req0 = 1'b0; wdata0 = 8'h00;
        watch(0, g, bits, lat);
        chk("t1_mosi_bits", bits, 8'h5B);
        chk("t1_latency", lat, 37);
        chk("t1_rdata0", rdata0, 8'hA6);
        chk("t1_rdata1", rdata1, 8'h00);
        wait_idle();

        // both held from reset: grants alternate starting with requester 0
        do_reset();
        slave_byte = 8'h81; wdata0 = 8'h11; wdata1 = 8'h22; req0 = 1'b1; req1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_gnt(who, g);
            gw[i] = who;
            if (i == 3) begin
                tick();
                req0 = 1'b0; req1 = 1'b0;
            end
            watch(who, g, bits, lat);
            chk("rr_latency", lat, 37);
            chk("rr_bits", bits, (who == 1) ? 8'h22 : 8'h11);
        end
        chk("rr_order0", gw[0], 0); chk("rr_order1", gw[1], 1);
        chk("rr_order2", gw[2], 0); chk("rr_order3", gw[3], 1);
        wait_idle();

        // reset after the third SCLK rise aborts with no done
        do_reset();
        slave_byte = 8'h99; wdata0 = 8'h3C; req0 = 1'b1;
        wait_gnt(who, g);
        tick();
        req0 = 1'b0;
        n = 0; rises = 0; ps = 1'b0;
        while (rises < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (sclk && !ps) rises++;
            ps = sclk;
        end
        chk("abort_rises", rises, 3);
        #1;
        rst = 1'b0;
        #1;
        chk("abort_ss", ss, 1); chk("abort_sclk", sclk, 0); chk("abort_busy", busy, 0);
        chk("abort_done", {done1, done0}, 0);
        tick();
        tick();
        rst = 1'b1;
        cnt = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (done0 || done1) cnt++;
        end
        chk("abort_no_done", cnt, 0);
        tick();
        slave_byte = 8'h5A; wdata0 = 8'h3C; req0 = 1'b1;
        wait_gnt(who, g);
        tick();
        req0 = 1'b0;
        watch(0, g, bits, lat);
        chk("post_abort_bits", bits, 8'h3C);
        chk("post_abort_lat", lat, 37);
        chk("post_abort_rdata0", rdata0, 8'h5A);
        wait_idle();

        // req1 dropped right after its grant
        slave_byte = 8'h4E; wdata1 = 8'hB2; req1 = 1'b1;
        wait_gnt(who, g);
        chk("drop_who", who, 1);
        tick();
        req1 = 1'b0;
        cnt = 0;
        for (int i = 0; i < D + C + 10; i++) begin
            @(negedge clk);
            if (done1) cnt++;
        end
        chk("drop_done1_count", cnt, 1);
        chk("drop_busy", busy, 0);
        chk("drop_rdata1", rdata1, 8'h4E);
        tick();

        // randomized requests; the model checks every cycle
        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(1, 3);
            wdata0 = 8'($urandom); wdata1 = 8'($urandom); slave_byte = 8'($urandom);
            pend0 = r[0]; pend1 = r[1];
            req0 = pend0; req1 = pend1;
            n = 0;
            while ((pend0 || pend1 || busy) && n < 400) begin
                @(negedge clk);
                n++;
                g0 = gnt0; g1 = gnt1;
                tick();
                if (g0) begin req0 = 1'b0; pend0 = 1'b0; wdata0 = 8'($urandom); end
                if (g1) begin req1 = 1'b0; pend1 = 1'b0; wdata1 = 8'($urandom); end
            end
            chk("rand_complete", (n < 400), 1);
        end
        wait_idle();

        // CLK_DIV=1 instance: 0xFF out on requester 1 with miso low, then 0x0F on 0 with miso high
        wdata1_b = 8'hFF; miso_b = 1'b0; req1_b = 1'b1;
        watch_b(1, bits, rises, lat);
        chk("b1_rises", rises, 8);
        chk("b1_bits", bits, 8'hFF);
        chk("b1_latency", lat, 19);
        chk("b1_rdata1", rdata1_b, 8'h00);
        chk("b1_rdata0", rdata0_b, 8'h00);
        repeat (4) tick();
        wdata0_b = 8'h0F; miso_b = 1'b1; req0_b = 1'b1;
        watch_b(0, bits, rises, lat);
        chk("b2_rises", rises, 8);
        chk("b2_bits", bits, 8'h0F);
        chk("b2_latency", lat, 19);
        chk("b2_rdata0", rdata0_b, 8'hFF);
        chk("b2_rdata1", rdata1_b, 8'h00);
        repeat (4) tick();
        chk("b_idle_ss", ss_b, 1);
        chk("b_idle_busy", busy_b, 0);
        chk("b_idle_done", {done1_b, done0_b}, 0);

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule
